// File: rtl/uncached_write_buffer_pkg.sv
// rtl/uncached_write_buffer_pkg.sv - shared types and AXI constants for the uncached write buffer
package uncached_write_buffer_pkg;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RESP
    } wbuf_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

endpackage

// File: rtl/wbuf_fifo.sv
// rtl/wbuf_fifo.sv - entry storage, pointers, count and parallel word-address hazard compare
// Optional store merging into the newest entry is enabled by WBUF_MERGE_EN.
module wbuf_fifo
    import uncached_write_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_addr,
    input  logic [31:0] push_data,
    input  logic [3:0]  push_be,
    input  logic        pop,
    input  logic        head_busy,
    input  logic [31:0] query_addr,
    output logic        query_hit,
    output logic        full,
    output logic        empty,
    output wbuf_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    wbuf_entry_t mem_q [DEPTH];
    wbuf_entry_t mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, newest, off;
    logic [CNT_W-1:0] count_q, count_d;
    logic merge, alloc;
    logic unused_ok;

    assign full   = (count_q == CNT_FULL);
    assign empty  = (count_q == '0);
    assign head   = mem_q[head_q];
    assign newest = tail_q - PTR_ONE;

`ifdef WBUF_MERGE_EN
    // The head cannot absorb bytes once its AW/W beats may already be on the bus.
    assign merge = push && !empty && (mem_q[newest].addr == push_addr[31:2])
                   && !((newest == head_q) && head_busy);
    assign unused_ok = ^{push_addr[1:0], query_addr[1:0]};
`else
    assign merge = 1'b0;
    assign unused_ok = ^{head_busy, newest, push_addr[1:0], query_addr[1:0]};
`endif

    assign alloc = push && !full && !merge;

    always_comb begin
        mem_d   = mem_q;
        head_d  = pop ? head_q + PTR_ONE : head_q;
        tail_d  = alloc ? tail_q + PTR_ONE : tail_q;
        count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
        if (alloc) begin
            mem_d[tail_q] = '{addr: push_addr[31:2], data: push_data, be: push_be};
        end
        if (merge) begin
            for (int b = 0; b < 4; b++) begin
                if (push_be[b]) begin
                    mem_d[newest].data[8*b +: 8] = push_data[8*b +: 8];
                end
            end
            mem_d[newest].be = mem_q[newest].be | push_be;
        end
    end

    always_comb begin
        query_hit = 1'b0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - head_q;
            if (({1'b0, off} < count_q) && (mem_q[i].addr == query_addr[31:2])) begin
                query_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uncached_write_buffer.sv
// rtl/uncached_write_buffer.sv - buffers uncached stores and drains them as single-beat AXI writes
// Optional store merging (WBUF_MERGE_EN) lives in wbuf_fifo.
module uncached_write_buffer
    import uncached_write_buffer_pkg::*;
#(
    parameter int         DEPTH  = 8,
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_addr,
    input  logic [31:0] push_data,
    input  logic [3:0]  push_be,
    output logic        full,
    output logic        empty,
    input  logic [31:0] query_addr,
    output logic        query_hit,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    wbuf_state_t state_q, state_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic        pop;
    wbuf_entry_t head;
    logic        unused_ok;

    wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (push_addr),
        .push_data  (push_data),
        .push_be    (push_be),
        .pop        (pop),
        .head_busy  (state_q != IDLE),
        .query_addr (query_addr),
        .query_hit  (query_hit),
        .full       (full),
        .empty      (empty),
        .head       (head)
    );

    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign awaddr  = {head.addr, 2'b00};
    assign awlen   = 4'd0;
    assign awsize  = AXI_SIZE_4B;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wdata   = head.data;
    assign wstrb   = head.be;
    assign wlast   = 1'b1;
    assign unused_ok = ^{bid, bresp};

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (!empty) state_d = SEND;
            end
            SEND: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if (awvalid && awready) aw_done_d = 1'b1;
                if (wvalid && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = RESP;
            end
            RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_uncached_write_buffer.sv
// tb/tb_uncached_write_buffer.sv - directed scoreboard bench for uncached_write_buffer
module tb_uncached_write_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, push = 1'b0;
    logic [31:0] push_addr = '0, push_data = '0, query_addr = '0;
    logic [3:0]  push_be = '0;
    logic        full, empty, query_hit;
    logic [3:0]  awid, awlen, awcache, wid, wstrb;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic        awvalid, wlast, wvalid, bready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [3:0]  bid = 4'd1;
    logic [1:0]  bresp = 2'b00;

    logic [67:0] sb [$];
    int n_checks = 0;
    int n_fail   = 0;

    uncached_write_buffer #(.DEPTH(8), .AXI_ID(4'd1)) dut (
        .clk(clk), .rst(rst), .push(push), .push_addr(push_addr), .push_data(push_data),
        .push_be(push_be), .full(full), .empty(empty), .query_addr(query_addr),
        .query_hit(query_hit), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        push = 1'b1; push_addr = a; push_data = d; push_be = be;
        if (!full) sb.push_back({a, d, be});
        step();
        push = 1'b0;
    endtask

    task automatic drain(input int n);
        int got = 0;
        int cyc = 0;
        logic [67:0] e;
        awready = 1'b1; wready = 1'b1;
        while (got < n && cyc < 200) begin
            if (bready) begin
                bvalid = 1'b1;
                if (sb.size() == 0) begin
                    check("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("awaddr", awaddr, e[67:36]);
                    check("wdata", wdata, e[35:4]);
                    check("wstrb", {28'd0, wstrb}, {28'd0, e[3:0]});
                end
                got++;
            end else begin
                bvalid = 1'b0;
            end
            step();
            cyc++;
        end
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        check("drain_count", got, n);
    endtask

    initial begin
        int cyc;
        step(); step();
        // reset state
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_awvalid", {31'd0, awvalid}, 32'd0);
        check("rst_wvalid", {31'd0, wvalid}, 32'd0);
        check("rst_bready", {31'd0, bready}, 32'd0);
        check("rst_query_hit", {31'd0, query_hit}, 32'd0);
        rst = 1'b0;
        step();

        // single write and its latency / constant fields
        push_one(32'h1FC0_0010, 32'hDEAD_BEEF, 4'hF);
        check("lat1_awvalid", {31'd0, awvalid}, 32'd0);
        check("lat1_empty", {31'd0, empty}, 32'd0);
        step();
        check("lat2_awvalid", {31'd0, awvalid}, 32'd1);
        check("lat2_wvalid", {31'd0, wvalid}, 32'd1);
        check("const_fields", {awid, wid, awlen, 5'd0, awsize, awburst, awlock, awcache, awprot, wlast},
              {4'd1, 4'd1, 4'd0, 5'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0, 1'b1});
        drain(1);
        step();
        check("single_empty_after_b", {31'd0, empty}, 32'd1);

        // fill to full, drop the ninth, drain in order
        for (int i = 0; i < 8; i++) begin
            push_one(32'h4000_0000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'(i + 1));
        end
        check("full_after_8", {31'd0, full}, 32'd1);
        push_one(32'h4000_0100, 32'hBAD0_BAD0, 4'hF);
        check("full_after_9th", {31'd0, full}, 32'd1);
        check("sb_size", 32'(sb.size()), 32'd8);
        drain(8);
        check("fill_empty", {31'd0, empty}, 32'd1);
        check("fill_full", {31'd0, full}, 32'd0);

        // W handshake well before AW
        push_one(32'h5000_0008, 32'h1234_5678, 4'hC);
        step();
        check("order_awvalid", {31'd0, awvalid}, 32'd1);
        wready = 1'b1;
        step();
        wready = 1'b0;
        check("order_wvalid_dropped", {31'd0, wvalid}, 32'd0);
        check("order_awvalid_held", {31'd0, awvalid}, 32'd1);
        check("order_bready_early", {31'd0, bready}, 32'd0);
        step(); step();
        check("order_bready_wait", {31'd0, bready}, 32'd0);
        check("order_awvalid_wait", {31'd0, awvalid}, 32'd1);
        awready = 1'b1;
        step();
        awready = 1'b0;
        check("order_awvalid_dropped", {31'd0, awvalid}, 32'd0);
        check("order_bready", {31'd0, bready}, 32'd1);
        drain(1);
        check("order_empty", {31'd0, empty}, 32'd1);

        // hazard query holds until the B handshake
        query_addr = 32'h8000_0043;
        check("hazard_before_push", {31'd0, query_hit}, 32'd0);
        push_one(32'h8000_0040, 32'h0000_00AA, 4'hF);
        check("hazard_hit", {31'd0, query_hit}, 32'd1);
        query_addr = 32'h8000_0044;
        #1;
        check("hazard_next_word", {31'd0, query_hit}, 32'd0);
        query_addr = 32'h8000_0043;
        awready = 1'b1; wready = 1'b1;
        cyc = 0;
        while (!bready && cyc < 20) begin
            step();
            cyc++;
        end
        check("hazard_reach_resp", {31'd0, bready}, 32'd1);
        check("hazard_hit_in_resp", {31'd0, query_hit}, 32'd1);
        bvalid = 1'b1;
        void'(sb.pop_front());
        step();
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        check("hazard_cleared", {31'd0, query_hit}, 32'd0);
        step();

`ifdef WBUF_MERGE_EN
        // stalled head, then two stores to the same word merge
        push_one(32'h9000_0000, 32'h5555_5555, 4'hF);
        step();
        check("merge_head_sending", {31'd0, awvalid}, 32'd1);
        push = 1'b1; push_addr = 32'hA000_0000; push_data = 32'h0000_0011; push_be = 4'h1;
        step();
        push_addr = 32'hA000_0000; push_data = 32'h0000_2200; push_be = 4'h2;
        step();
        push = 1'b0;
        sb.push_back({32'hA000_0000, 32'h0000_2211, 4'h3});
        drain(2);
        check("merge_empty", {31'd0, empty}, 32'd1);
`endif

        // reset while in SEND with three entries held
        query_addr = 32'h6000_0004;
        push_one(32'h6000_0000, 32'h1, 4'hF);
        push_one(32'h6000_0004, 32'h2, 4'hF);
        push_one(32'h6000_0008, 32'h3, 4'hF);
        check("rst_mid_awvalid_before", {31'd0, awvalid}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        check("rst_mid_awvalid", {31'd0, awvalid}, 32'd0);
        check("rst_mid_wvalid", {31'd0, wvalid}, 32'd0);
        check("rst_mid_bready", {31'd0, bready}, 32'd0);
        check("rst_mid_empty", {31'd0, empty}, 32'd1);
        check("rst_mid_full", {31'd0, full}, 32'd0);
        check("rst_mid_query", {31'd0, query_hit}, 32'd0);

        push_one(32'h7000_0010, 32'hFEED_F00D, 4'h5);
        drain(1);
        check("post_rst_empty", {31'd0, empty}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
